// File: rtl/prog_loader_pkg.sv
// Shared loader definitions: FSM state encoding and byte-counter width,
// reused by the CPU top and benches.
package prog_loader_pkg;
  localparam int BYTE_CNT_W = 2;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/prog_loader_word_assembler.sv
// Collects four UART bytes little-endian into a 32-bit word; o_word_ready
// strobes combinationally in the cycle the fourth byte is presented.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);
  logic [BYTE_CNT_W-1:0] r_cnt;
  logic [23:0]           r_shift;

  // Bytes enter at the top so after three bytes r_shift = {b2, b1, b0}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_byte_vld) begin
      r_cnt   <= r_cnt + BYTE_CNT_W'(1);
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

  assign o_word       = {i_byte, r_shift};
  assign o_word_ready = i_byte_vld && (r_cnt == BYTE_CNT_W'(3));
endmodule

// File: rtl/prog_loader.sv
// Boot loader: fills instruction memory from the UART byte stream while
// holding the CPU in reset, then hands memory to the CPU fetch port.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CELL_NUMBERS = 16,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_reload,
  input  logic [31:0]           i_cpu_pc,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic                  o_imem_we,
  output logic [31:0]           o_imem_wdata,
  output logic                  o_cpu_rst,
  output logic                  o_load_done
);
  localparam int WIDX_W = (CELL_NUMBERS > 1) ? $clog2(CELL_NUMBERS) : 1;

  state_t                r_state, w_next;
  logic [WIDX_W-1:0]     r_word_idx;
  logic [ADDR_WIDTH-1:0] r_load_addr;
  logic [31:0]           r_wdata;
  logic                  w_last, w_accept, w_reload, w_word_ready;
  logic [31:0]           w_word;
  logic                  w_unused_pc;

  assign w_last   = (r_word_idx == WIDX_W'(CELL_NUMBERS - 1));
  // A byte arriving during the final COMMIT would belong to a word past the
  // program end, so it is not accepted.
  assign w_accept = i_rx_valid &&
                    ((r_state == ST_LOAD) || ((r_state == ST_COMMIT) && !w_last));
  assign w_reload = i_reload && (r_state == ST_DONE);

  word_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_reload),
    .i_byte_vld  (w_accept),
    .i_byte      (i_rx_data),
    .o_word      (w_word),
    .o_word_ready(w_word_ready)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD:   if (w_word_ready) w_next = ST_COMMIT;
      ST_COMMIT: w_next = w_last ? ST_DONE : ST_LOAD;
      ST_DONE:   if (i_reload) w_next = ST_LOAD;
      default:   w_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_word_idx  <= '0;
      r_load_addr <= '0;
      r_wdata     <= '0;
    end else begin
      r_state <= w_next;
      if (w_word_ready) begin
        r_wdata     <= w_word;
        r_load_addr <= ADDR_WIDTH'(r_word_idx);
      end
      if (r_state == ST_COMMIT)
        r_word_idx <= w_last ? '0 : r_word_idx + WIDX_W'(1);
      else if (w_reload)
        r_word_idx <= '0;
    end
  end

  assign o_imem_we    = (r_state == ST_COMMIT);
  assign o_imem_wdata = r_wdata;
  assign o_imem_addr  = (r_state == ST_DONE) ? i_cpu_pc[ADDR_WIDTH+1:2] : r_load_addr;
  assign o_cpu_rst    = (r_state != ST_DONE);
  assign o_load_done  = (r_state == ST_DONE);

  assign w_unused_pc = ^{i_cpu_pc[31:ADDR_WIDTH+2], i_cpu_pc[1:0]};
endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: instance 0 loads 4 words, instance 1 loads 1 word;
// writes are logged at negedge and compared with words built from the byte stream.
module tb_prog_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid [2];
  logic [7:0] rx_data  [2];
  logic       reload   [2];
  logic [31:0] cpu_pc  [2];
  logic [7:0] imem_addr  [2];
  logic       imem_we    [2];
  logic [31:0] imem_wdata [2];
  logic       cpu_rst    [2];
  logic       load_done  [2];

  int errors = 0;
  int checks = 0;
  logic [40:0] wr_q [$];  // {dut, addr, data}

  always #5 clk = ~clk;

  prog_loader #(.CELL_NUMBERS(4), .ADDR_WIDTH(8)) u_dut4 (
    .clk(clk), .rst(rst), .i_rx_valid(rx_valid[0]), .i_rx_data(rx_data[0]),
    .i_reload(reload[0]), .i_cpu_pc(cpu_pc[0]), .o_imem_addr(imem_addr[0]),
    .o_imem_we(imem_we[0]), .o_imem_wdata(imem_wdata[0]),
    .o_cpu_rst(cpu_rst[0]), .o_load_done(load_done[0]));

  prog_loader #(.CELL_NUMBERS(1), .ADDR_WIDTH(8)) u_dut1 (
    .clk(clk), .rst(rst), .i_rx_valid(rx_valid[1]), .i_rx_data(rx_data[1]),
    .i_reload(reload[1]), .i_cpu_pc(cpu_pc[1]), .o_imem_addr(imem_addr[1]),
    .o_imem_we(imem_we[1]), .o_imem_wdata(imem_wdata[1]),
    .o_cpu_rst(cpu_rst[1]), .o_load_done(load_done[1]));

  always @(negedge clk) begin
    if (imem_we[0]) wr_q.push_back({1'b0, imem_addr[0], imem_wdata[0]});
    if (imem_we[1]) wr_q.push_back({1'b1, imem_addr[1], imem_wdata[1]});
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b);
    rx_valid[d] = 1'b1; rx_data[d] = b;
    step();
    rx_valid[d] = 1'b0; rx_data[d] = 8'h00;
  endtask

  function automatic int count_writes(input int d);
    int n = 0;
    foreach (wr_q[i]) if (wr_q[i][40] == d[0]) n++;
    return n;
  endfunction

  // Loads n words of random bytes and checks the write log and the handover timing.
  task automatic do_load(input int d, input int n, input string tag);
    logic [7:0]  b [$];
    logic [31:0] w;
    int k;
    wr_q.delete();
    for (int i = 0; i < 4*n; i++) b.push_back(8'($urandom));
    for (int i = 0; i < 4*n; i++) begin
      send_byte(d, b[i]);
      if (i != 4*n-1) repeat ((i == 3) ? 0 : $urandom_range(0, 2)) step();
    end
    @(negedge clk);
    checks++;
    if (imem_we[d] !== 1'b1 || imem_addr[d] !== 8'(n-1) || cpu_rst[d] !== 1'b1 || load_done[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s_last_commit: we=%b addr=%0d cpu_rst=%b done=%b, want we=1 addr=%0d cpu_rst=1 done=0",
               tag, imem_we[d], imem_addr[d], cpu_rst[d], load_done[d], n-1);
    end
    @(negedge clk);
    checks++;
    if (load_done[d] !== 1'b1 || cpu_rst[d] !== 1'b0 || imem_we[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: done=%b cpu_rst=%b we=%b, want 1 0 0", tag, load_done[d], cpu_rst[d], imem_we[d]);
    end
    step();
    checks++;
    if (count_writes(d) != n) begin
      errors++;
      $display("FAIL %s_write_count: got %0d want %0d", tag, count_writes(d), n);
    end
    k = 0;
    foreach (wr_q[i]) begin
      if (wr_q[i][40] == d[0] && k < n) begin
        w = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
        checks++;
        if (wr_q[i][39:32] !== 8'(k) || wr_q[i][31:0] !== w) begin
          errors++;
          $display("FAIL %s_write%0d: addr=%0d data=%h want addr=%0d data=%h",
                   tag, k, wr_q[i][39:32], wr_q[i][31:0], k, w);
        end
        k++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (imem_we[d] !== 1'b0 || imem_wdata[d] !== 32'h0 || imem_addr[d] !== 8'h0 ||
          cpu_rst[d] !== 1'b1 || load_done[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s_dut%0d: we=%b wdata=%h addr=%h cpu_rst=%b done=%b, want 0 0 0 1 0",
                 tag, d, imem_we[d], imem_wdata[d], imem_addr[d], cpu_rst[d], load_done[d]);
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; #2;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    check_reset_outputs("reset");
    step(); rst = 1'b0; step();
    check_reset_outputs("reset_release");
  endtask

  task automatic test_single_word();
    logic [7:0] seq [4];
    seq = '{8'h13, 8'h00, 8'h10, 8'h00};
    wr_q.delete();
    foreach (seq[i]) send_byte(0, seq[i]);
    repeat (3) step();
    checks++;
    if (count_writes(0) != 1 || wr_q.size() < 1 || wr_q[0][39:0] !== {8'd0, 32'h00100013}) begin
      errors++;
      $display("FAIL single_word: writes=%0d first=%h want 1 write 00_00100013",
               count_writes(0), (wr_q.size() > 0) ? wr_q[0][39:0] : 40'h0);
    end
    checks++;
    if (cpu_rst[0] !== 1'b1 || load_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_word_cpu_rst: cpu_rst=%b done=%b want 1 0", cpu_rst[0], load_done[0]);
    end
  endtask

  task automatic test_full_load();
    apply_reset();
    do_load(0, 4, "full_load");
  endtask

  task automatic test_done_fetch();
    logic [31:0] pc;
    for (int i = 0; i < 6; i++) begin
      pc = (i == 0) ? 32'h0000000C : $urandom;
      cpu_pc[0] = pc;
      @(negedge clk);
      checks++;
      if (imem_addr[0] !== 8'((pc >> 2) % 256) || imem_we[0] !== 1'b0) begin
        errors++;
        $display("FAIL done_fetch pc=%h: addr=%0d we=%b want addr=%0d we=0",
                 pc, imem_addr[0], imem_we[0], (pc >> 2) % 256);
      end
      step();
    end
    cpu_pc[0] = 32'h0;
    wr_q.delete();
    for (int i = 0; i < 9; i++) send_byte(0, 8'($urandom));
    step();
    checks++;
    if (wr_q.size() != 0 || load_done[0] !== 1'b1 || cpu_rst[0] !== 1'b0) begin
      errors++;
      $display("FAIL done_ignore_rx: writes=%0d done=%b cpu_rst=%b want 0 1 0",
               wr_q.size(), load_done[0], cpu_rst[0]);
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 6; i++) send_byte(0, 8'($urandom));
    rst = 1'b1; #2;
    check_reset_outputs("rst_mid");
    step(); rst = 1'b0; step();
    do_load(0, 4, "rst_reload");
  endtask

  task automatic test_reload();
    reload[0] = 1'b1; rx_valid[0] = 1'b1; rx_data[0] = 8'hA5;
    step();
    reload[0] = 1'b0; rx_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_rst[0] !== 1'b1 || load_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL reload_state: cpu_rst=%b done=%b want 1 0", cpu_rst[0], load_done[0]);
    end
    step();
    do_load(0, 4, "reload");
  endtask

  task automatic test_cell1();
    wr_q.delete();
    apply_reset();
    do_load(1, 1, "cell1");
    for (int i = 0; i < 4; i++) send_byte(1, 8'($urandom));
    step();
    checks++;
    if (count_writes(1) != 1) begin
      errors++;
      $display("FAIL cell1_extra: writes=%0d want 1", count_writes(1));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rx_valid[d] = 1'b0; rx_data[d] = 8'h0; reload[d] = 1'b0; cpu_pc[d] = 32'h0;
    end
    #3;
    test_reset();
    test_single_word();
    test_full_load();
    test_done_fetch();
    test_rst_mid();
    test_reload();
    test_cell1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
